// File: rtl/uart_tx.sv
// uart_tx: LSB-first UART transmitter that times each serial bit by CLK_DIV rising edges of bclk.
// Optional feature macro UART_TX_PARITY_EN inserts one parity bit between the data and the stop bits.

module uart_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_bclk,
   input  logic [DATA_WIDTH-1:0] i_tx_data,
   input  logic                  i_tx_valid,
   output logic                  o_tx_ready,
   input  logic                  i_stop2,
   input  logic                  i_parity_odd,
   output logic                  o_tx,
   output logic                  o_tx_busy
);

   localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W  = $clog2(DATA_WIDTH);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

`ifdef UART_TX_PARITY_EN
   // Even parity is the XOR of the word; odd parity is its complement.
   function automatic logic f_parity(input logic [DATA_WIDTH-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction
`else
   logic w_unused_parity;
   assign w_unused_parity = i_parity_odd;
`endif

   state_t                r_state;
   logic                  r_bclk_d;
   logic [TICK_W-1:0]     r_tick;
   logic [BIT_W-1:0]      r_bit;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_stop2;
   logic                  r_stop_second;
   logic                  r_tx;
   logic                  r_tx_ready;
   logic                  r_tx_busy;
`ifdef UART_TX_PARITY_EN
   logic                  r_par;
`endif

   state_t                w_state;
   logic [TICK_W-1:0]     w_tick;
   logic [BIT_W-1:0]      w_bit;
   logic [DATA_WIDTH-1:0] w_shift;
   logic                  w_stop2;
   logic                  w_stop_second;
   logic                  w_tx;
   logic                  w_rise;
   logic                  w_bit_end;
`ifdef UART_TX_PARITY_EN
   logic                  w_par;
`endif

   assign w_rise    = i_bclk & ~r_bclk_d;
   assign w_bit_end = w_rise & (r_tick == TICK_LAST);

   // Next-state, counter, shift and line-level logic for the framing FSM.
   always_comb begin
      w_state       = r_state;
      w_tick        = r_tick;
      w_bit         = r_bit;
      w_shift       = r_shift;
      w_stop2       = r_stop2;
      w_stop_second = r_stop_second;
      w_tx          = r_tx;
`ifdef UART_TX_PARITY_EN
      w_par         = r_par;
`endif

      // Ticks only advance inside a frame, so a rise seen in IDLE (including the accept edge) is ignored.
      if ((r_state != S_IDLE) && w_rise) begin
         if (w_bit_end) begin
            w_tick = TICK_W'(0);
         end else begin
            w_tick = r_tick + TICK_W'(1);
         end
      end else begin
         w_tick = r_tick;
      end

      case (r_state)
         S_IDLE: begin
            w_tx = 1'b1;
            if (i_tx_valid && r_tx_ready) begin
               w_state       = S_START;
               w_tick        = TICK_W'(0);
               w_bit         = BIT_W'(0);
               w_shift       = i_tx_data;
               w_stop2       = i_stop2;
               w_stop_second = 1'b0;
`ifdef UART_TX_PARITY_EN
               w_par         = f_parity(i_tx_data, i_parity_odd);
`endif
               w_tx          = 1'b0;
            end else begin
               w_state = S_IDLE;
            end
         end

         S_START: begin
            if (w_bit_end) begin
               w_state = S_DATA;
               w_tx    = r_shift[0];
            end else begin
               w_tx = 1'b0;
            end
         end

         S_DATA: begin
            if (w_bit_end) begin
               w_shift = {1'b0, r_shift[DATA_WIDTH-1:1]};
               if (r_bit == BIT_LAST) begin
                  w_bit = BIT_W'(0);
`ifdef UART_TX_PARITY_EN
                  w_state = S_PARITY;
                  w_tx    = r_par;
`else
                  w_state       = S_STOP;
                  w_stop_second = 1'b0;
                  w_tx          = 1'b1;
`endif
               end else begin
                  w_bit = r_bit + BIT_W'(1);
                  w_tx  = r_shift[1];
               end
            end else begin
               w_tx = r_shift[0];
            end
         end

`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (w_bit_end) begin
               w_state       = S_STOP;
               w_stop_second = 1'b0;
               w_tx          = 1'b1;
            end else begin
               w_tx = r_par;
            end
         end
`endif

         S_STOP: begin
            w_tx = 1'b1;
            if (w_bit_end) begin
               if (r_stop2 && !r_stop_second) begin
                  w_stop_second = 1'b1;
               end else begin
                  w_stop_second = 1'b0;
                  w_state       = S_IDLE;
               end
            end else begin
               w_state = S_STOP;
            end
         end

         default: begin
            w_state = S_IDLE;
            w_tx    = 1'b1;
         end
      endcase
   end

   // State and datapath registers; ready/busy are registered from the next state so they align with tx.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state       <= S_IDLE;
         r_bclk_d      <= 1'b0;
         r_tick        <= TICK_W'(0);
         r_bit         <= BIT_W'(0);
         r_shift       <= {DATA_WIDTH{1'b0}};
         r_stop2       <= 1'b0;
         r_stop_second <= 1'b0;
         r_tx          <= 1'b1;
         r_tx_ready    <= 1'b1;
         r_tx_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_par         <= 1'b0;
`endif
      end else begin
         r_state       <= w_state;
         r_bclk_d      <= i_bclk;
         r_tick        <= w_tick;
         r_bit         <= w_bit;
         r_shift       <= w_shift;
         r_stop2       <= w_stop2;
         r_stop_second <= w_stop_second;
         r_tx          <= w_tx;
         r_tx_ready    <= (w_state == S_IDLE);
         r_tx_busy     <= (w_state != S_IDLE);
`ifdef UART_TX_PARITY_EN
         r_par         <= w_par;
`endif
      end
   end

   assign o_tx       = r_tx;
   assign o_tx_ready = r_tx_ready;
   assign o_tx_busy  = r_tx_busy;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that takes the `bclk` produced by `baud_generator` and turns it into a timing reference for framing. It accepts parallel words over a valid/ready handshake and shifts them out LSB-first on `tx` as start, data, optional parity and stop bits. It sits directly downstream of the baud generator, in the same `clk` domain.

## Interface
- `DATA_WIDTH`, 8: data bits per frame (5..9 legal).
- `CLK_DIV`, 16: `bclk` rising edges per serial bit.
- `clk`  in  1  system clock; all logic on posedge.
- `reset_n`  in  1  **synchronous, active-low reset**; one clock.
- `bclk`  in  1  baud clock from `baud_generator`; a level signal sampled in the `clk` domain.
- `tx_data`  in  DATA_WIDTH  word to send; sampled at accept.
- `tx_valid`  in  1  word available.
- `tx_ready`  out  1  block can accept a word (IDLE only).
- `stop2`  in  1  1 = two stop bits, 0 = one; sampled at accept.
- `parity_odd`  in  1  1 = odd parity, 0 = even; sampled at accept; ignored without `UART_TX_PARITY_EN`.
- `tx`  out  1  serial line; idles high.
- `tx_busy`  out  1  frame in progress; always `~tx_ready`.

## Operation
- Edge detect: `bclk_d` is `bclk` registered once. `rise = bclk & ~bclk_d`. `bclk_d` resets to 0.
- Tick counter: `$clog2(CLK_DIV)` bits. It clears on accept and on every bit boundary, and increments on each `rise`. A bit ends on the `rise` where the counter equals CLK_DIV-1.
- Bit counter: `$clog2(DATA_WIDTH)` bits, counting data bits sent.
- Shift register: DATA_WIDTH bits, shifted right at each data-bit end. `tx` is driven from bit 0.
- States and transitions:
  - IDLE: `tx`=1, `tx_ready`=1. On `tx_valid & tx_ready`, latch `tx_data`, `stop2` and `parity_odd`, then go to START.
  - START: `tx`=0 for one bit time, then go to DATA.
  - DATA: `tx` = shift[0] for each bit. After DATA_WIDTH bits, go to PARITY if the macro is defined, otherwise STOP.
  - PARITY: `tx` = ^data for even, ~^data for odd, computed on the latched word. After one bit time, go to STOP.
  - STOP: `tx`=1 for 1 bit time, or 2 if the latched `stop2`=1. Then go to IDLE.
- `tx_data`, `stop2` and `parity_odd` may change freely once accepted; the frame is unaffected.
- If `bclk` stops (for example a divisor change), the FSM holds its state and `tx` holds its level.

## Timing
- All outputs are registered.
- Reset values: `tx`=1, `tx_ready`=1, `tx_busy`=0, state IDLE, all counters 0.
- Reset takes effect at the first posedge with `reset_n`=0.
- Reset mid-frame: the frame is aborted, `tx`=1 at that edge, and the word is lost.
- Accept edge: at the posedge where `tx_valid & tx_ready`, `tx` goes to 0 and `tx_ready` goes to 0. No extra latency.
- Start-bit length: from the accept edge to the CLK_DIV-th following `rise`. It therefore equals one bit time minus up to one `bclk` period (accepted jitter).
- Later bits: exactly CLK_DIV `bclk` periods each.
- End of frame: at the edge ending the last stop bit, state goes to IDLE and `tx_ready`=1.
- Back-to-back: if `tx_valid` is held, the next accept happens on the first IDLE cycle. There is no idle-high gap beyond the stop bit(s).
- Spurious `rise` right after reset (`bclk`=1, `bclk_d`=0) happens only in IDLE, where it has no effect.
- A `rise` coinciding with accept is not counted toward the start bit.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state exists and one parity bit follows the data.
  - `parity_odd` selects odd/even.
  - Frame length is 1+DATA_WIDTH+1+(1|2) bits.
- Not defined:
  - No PARITY state; `parity_odd` is unused.
  - Frame length is 1+DATA_WIDTH+(1|2) bits.

## Test plan
- Reset: hold `reset_n`=0 for 3 clk while `bclk` toggles -> `tx`=1, `tx_ready`=1, `tx_busy`=0 throughout.
- 8N1 frame, no macro, CLK_DIV=16, bench `bclk` rising every 4 clk: send 0xA5 -> `tx` = 0,1,0,1,0,0,1,0,1,1, each bit 64 clk (start bit 61..64 clk). `tx_ready` returns to 1 about 640 clk after accept.
- Parity, macro on: 0x07 even -> parity bit 1; 0x07 odd -> parity bit 0; 0x00 even -> parity bit 0.
- `stop2`=1 with 0xFF -> `tx` high for 8 data bits + 128 clk of stop. Next accept is not before then.
- Back-to-back: `tx_valid` held with 0x55 then 0xAA -> second start bit falls immediately after the first stop bit. No extra high time; exactly 2 accepts.
- Reset mid-frame: assert `reset_n`=0 during data bit 3 -> `tx`=1 the next edge, `tx_ready`=1. A new word after release is sent correctly from its start bit.
